// File: rtl/sa_pkg.sv
// sa_pkg: shared job sizes, core request codes and bridge FSM states
package sa_pkg;
  localparam int SA_IN_WORDS = 32;
  localparam int SA_OUT_WORDS = 16;
  localparam int SA_CAPTURE_DELAY = 2;
  localparam logic [1:0] RD_WR_IDLE = 2'b00;
  localparam logic [1:0] RD_WR_LOAD = 2'b10;
  localparam logic [1:0] RD_WR_OUT = 2'b11;
  typedef enum logic [2:0] {IDLE, WAIT_RD, INGRESS, WAIT_WR, CAPTURE, DRAIN} state_t;
endpackage

// File: rtl/sa_sync_fifo.sv
// sa_sync_fifo: synchronous first-word-fall-through FIFO with occupancy count
module sa_sync_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [DW-1:0]                wr_data,
  input  logic                         rd_en,
  output logic [DW-1:0]                rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
endmodule

// File: rtl/sa_stream_bridge.sv
// sa_stream_bridge: AXI-Stream <-> systolic-array bridge; define SA_STREAM_BRIDGE_TLAST_CHECK_EN to flag misplaced s_axis_tlast
module sa_stream_bridge
  import sa_pkg::*;
#(
  parameter int IN_WORDS = SA_IN_WORDS,
  parameter int OUT_WORDS = SA_OUT_WORDS,
  parameter int CAPTURE_DELAY = SA_CAPTURE_DELAY
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ctrl_start,
  output logic        ctrl_busy,
  output logic        ctrl_done,
  output logic        ctrl_err,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        sa_start,
  input  logic [1:0]  sa_start_rd_wr,
  output logic        sa_read_data_vld,
  output logic [31:0] sa_data_in,
  input  logic [31:0] sa_data_out,
  input  logic        sa_done
);
  localparam int IW = $clog2(IN_WORDS + 1);
  localparam int OW = $clog2(OUT_WORDS + 1);
  localparam int DLW = $clog2(CAPTURE_DELAY + 1);
  state_t state, state_n;
  logic start_q, start_go, hs_in, hs_out, in_last, cap_wr, cap_last, finish, err_set, tlast_err;
  logic done_seen, fifo_empty, fifo_full;
  logic [IW-1:0] in_cnt;
  logic [OW-1:0] cap_cnt, out_cnt, fifo_cnt;
  logic [DLW-1:0] dly_cnt;
  logic [31:0] fifo_head;
  logic [OW:0] unused_fifo;
  assign unused_fifo = {fifo_full, fifo_cnt};
  assign ctrl_busy = state != IDLE;
  assign s_axis_tready = state == INGRESS;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata = fifo_empty ? '0 : fifo_head;
  assign m_axis_tlast = m_axis_tvalid && out_cnt == OW'(OUT_WORDS - 1);
  assign start_go = state == IDLE && ctrl_start && !start_q;
  assign hs_in = s_axis_tvalid && s_axis_tready;
  assign hs_out = m_axis_tvalid && m_axis_tready;
  assign in_last = hs_in && in_cnt == IW'(IN_WORDS - 1);
  assign cap_wr = state == CAPTURE && dly_cnt <= DLW'(1);
  assign cap_last = cap_wr && cap_cnt == OW'(OUT_WORDS - 1);
  assign finish = state == DRAIN && (done_seen || sa_done) &&
                  ((hs_out && out_cnt == OW'(OUT_WORDS - 1)) || out_cnt == OW'(OUT_WORDS));
  assign err_set = tlast_err || (sa_done && state inside {WAIT_RD, INGRESS, WAIT_WR, CAPTURE}) ||
                   (state == INGRESS && sa_start_rd_wr == RD_WR_OUT);
`ifdef SA_STREAM_BRIDGE_TLAST_CHECK_EN
  assign tlast_err = hs_in && (s_axis_tlast != (in_cnt == IW'(IN_WORDS - 1)));
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign tlast_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_go ? WAIT_RD : IDLE;
      WAIT_RD: state_n = sa_start_rd_wr == RD_WR_LOAD ? INGRESS : WAIT_RD;
      INGRESS: state_n = in_last ? WAIT_WR : INGRESS;
      WAIT_WR: state_n = sa_start_rd_wr == RD_WR_OUT ? CAPTURE : WAIT_WR;
      CAPTURE: state_n = cap_last ? DRAIN : CAPTURE;
      DRAIN:   state_n = finish ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      start_q <= 1'b0;
      sa_start <= 1'b0;
      ctrl_done <= 1'b0;
      ctrl_err <= 1'b0;
      done_seen <= 1'b0;
      sa_read_data_vld <= 1'b0;
      sa_data_in <= '0;
      in_cnt <= '0;
      cap_cnt <= '0;
      out_cnt <= '0;
      dly_cnt <= '0;
    end else begin
      start_q <= ctrl_start;
      sa_start <= start_go;
      ctrl_done <= finish;
      ctrl_err <= start_go ? 1'b0 : ctrl_err || err_set;
      done_seen <= start_go ? 1'b0 : done_seen || (sa_done && state != IDLE);
      sa_read_data_vld <= hs_in;
      if (hs_in) sa_data_in <= s_axis_tdata;
      in_cnt <= in_last ? '0 : in_cnt + IW'(hs_in);
      cap_cnt <= cap_last ? '0 : cap_cnt + OW'(cap_wr);
      out_cnt <= finish ? '0 : out_cnt + OW'(hs_out);
      dly_cnt <= (state == WAIT_WR && sa_start_rd_wr == RD_WR_OUT) ? DLW'(CAPTURE_DELAY) :
                 cap_last ? '0 : dly_cnt > DLW'(1) ? dly_cnt - DLW'(1) : dly_cnt;
    end
  sa_sync_fifo #(.DW(32), .DEPTH(OUT_WORDS)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .wr_en(cap_wr),
    .wr_data(sa_data_out),
    .rd_en(hs_out),
    .rd_data(fifo_head),
    .count(fifo_cnt),
    .empty(fifo_empty),
    .full(fifo_full)
  );
endmodule

// File: tb/tb_sa_stream_bridge.sv
// tb_sa_stream_bridge: randomized self-checking bench with a queue/cycle-level job model
module tb_sa_stream_bridge;
  import sa_pkg::*;
  localparam int IW = SA_IN_WORDS;
  localparam int OW = SA_OUT_WORDS;
`ifdef SA_STREAM_BRIDGE_TLAST_CHECK_EN
  localparam bit TLAST_CHK = 1'b1;
`else
  localparam bit TLAST_CHK = 1'b0;
`endif
  logic clk = 0, rstn = 1;
  logic ctrl_start, ctrl_busy, ctrl_done, ctrl_err;
  logic [31:0] s_axis_tdata, m_axis_tdata, sa_data_in, sa_data_out;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic sa_start, sa_read_data_vld, sa_done;
  logic [1:0] sa_start_rd_wr;
  int n_chk = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, start_cnt = 0, vld_cnt = 0;
  bit err_exp = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ctrl_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sa_start) start_cnt++;
    if (sa_read_data_vld) vld_cnt++;
  end
  sa_stream_bridge dut (
    .clk(clk), .rstn(rstn),
    .ctrl_start(ctrl_start), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_err(ctrl_err),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .sa_start(sa_start), .sa_start_rd_wr(sa_start_rd_wr), .sa_read_data_vld(sa_read_data_vld),
    .sa_data_in(sa_data_in), .sa_data_out(sa_data_out), .sa_done(sa_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, ctrl_busy, 0);
    check({tag, "_done"}, ctrl_done, 0);
    check({tag, "_err"}, ctrl_err, 0);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_m_tdata"}, m_axis_tdata, 0);
    check({tag, "_m_tlast"}, m_axis_tlast, 0);
    check({tag, "_sa_start"}, sa_start, 0);
    check({tag, "_sa_vld"}, sa_read_data_vld, 0);
    check({tag, "_sa_data_in"}, sa_data_in, 0);
  endtask
  task automatic start_job();
    @(negedge clk);
    check("err_before_start", ctrl_err, err_exp);
    ctrl_start = 1;
    @(negedge clk);
    ctrl_start = 0;
    check("sa_start_rise", sa_start, 1);
    check("busy_after_start", ctrl_busy, 1);
    check("err_cleared", ctrl_err, 0);
    @(negedge clk);
    check("sa_start_one_cycle", sa_start, 0);
    sa_start_rd_wr = RD_WR_LOAD;
    @(negedge clk);
    sa_start_rd_wr = RD_WR_IDLE;
  endtask
  task automatic do_ingress(input int pct, input bit seq, input int done_beat, input int last_beat);
    int sent;
    bit hs_prev, injected;
    logic [31:0] exp_d;
    sent = 0;
    hs_prev = 0;
    injected = 0;
    exp_d = 0;
    for (int c = 0; c < 4000 && (sent < IW || hs_prev); c++) begin
      @(negedge clk);
      check("strobe_vld", sa_read_data_vld, hs_prev);
      if (hs_prev) check("strobe_data", sa_data_in, exp_d);
      sa_done = 0;
      if (sent == done_beat && !injected) begin
        sa_done = 1;
        injected = 1;
      end
      if (hs_prev || !s_axis_tvalid) begin
        s_axis_tvalid = sent < IW && $urandom_range(99) < pct;
        s_axis_tdata = seq ? 32'(sent) : $urandom;
        s_axis_tlast = sent == last_beat;
      end
      hs_prev = s_axis_tvalid && s_axis_tready;
      if (hs_prev) begin
        exp_d = s_axis_tdata;
        sent++;
      end
    end
    sa_done = 0;
    check("beats_in", sent, IW);
    check("tready_drop", s_axis_tready, 0);
  endtask
  task automatic do_egress(input int rdy_mode, input bit seq, input bit late, output int exp_done);
    logic [31:0] words [OW];
    int got, last_beat_cyc, done_at;
    got = 0;
    last_beat_cyc = 0;
    done_at = 0;
    for (int i = 0; i < OW; i++) words[i] = seq ? 32'hA0 + 32'(i) : $urandom;
    @(negedge clk);
    sa_start_rd_wr = RD_WR_OUT;
    @(negedge clk);
    sa_start_rd_wr = RD_WR_IDLE;
    fork
      begin
        for (int i = 0; i < OW; i++) begin
          @(negedge clk);
          sa_data_out = words[i];
        end
        @(negedge clk);
        sa_data_out = $urandom;
        if (!late) begin
          sa_done = 1;
          done_at = cyc + 1;
          @(negedge clk);
          sa_done = 0;
        end
      end
      begin
        bit stall;
        logic [31:0] held;
        stall = 0;
        held = 0;
        for (int c = 0; c < 400 && got < OW; c++) begin
          @(negedge clk);
          if (stall) begin
            check("hold_vld", m_axis_tvalid, 1);
            check("hold_data", m_axis_tdata, held);
          end
          m_axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? c[0] : 1'($urandom_range(1));
          if (m_axis_tvalid && m_axis_tready) begin
            check("out_data", m_axis_tdata, words[got]);
            check("out_last", m_axis_tlast, got == OW - 1);
            got++;
            last_beat_cyc = cyc + 1;
          end
          stall = m_axis_tvalid && !m_axis_tready;
          held = m_axis_tdata;
        end
        check("beats_out", got, OW);
      end
    join
    if (late) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("late_busy", ctrl_busy, 1);
        check("late_no_done", ctrl_done, 0);
      end
      sa_done = 1;
      done_at = cyc + 1;
      @(negedge clk);
      sa_done = 0;
      check("late_done", ctrl_done, 1);
      check("late_idle", ctrl_busy, 0);
    end
    exp_done = last_beat_cyc > done_at ? last_beat_cyc : done_at;
  endtask
  task automatic run_job(input int pct, input bit seq, input int done_beat, input int last_beat,
                         input int rdy_mode, input bit late, input bit spurious);
    int d0, s0, v0, exp_done;
    bit exp_err;
    d0 = done_cnt;
    s0 = start_cnt;
    v0 = vld_cnt;
    exp_err = done_beat >= 0 || (TLAST_CHK && last_beat != IW - 1);
    start_job();
    do_ingress(pct, seq, done_beat, last_beat);
    if (spurious) begin
      ctrl_start = 1;
      @(negedge clk);
      ctrl_start = 0;
    end
    do_egress(rdy_mode, seq, late, exp_done);
    for (int c = 0; c < 100 && done_cnt == d0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("done_cycle", done_cyc, exp_done);
    check("busy_end", ctrl_busy, 0);
    check("err_end", ctrl_err, exp_err);
    check("sa_start_count", start_cnt - s0, 1);
    check("strobe_count", vld_cnt - v0, IW);
    err_exp = exp_err;
  endtask
  task automatic do_abort();
    int d0;
    d0 = done_cnt;
    start_job();
    do_ingress(100, 0, -1, IW - 1);
    m_axis_tready = 0;
    @(negedge clk);
    sa_start_rd_wr = RD_WR_OUT;
    @(negedge clk);
    sa_start_rd_wr = RD_WR_IDLE;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sa_data_out = $urandom;
    end
    @(negedge clk);
    check("pre_abort_tvalid", m_axis_tvalid, 1);
    rstn = 0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rstn = 1;
    err_exp = 0;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_tvalid", m_axis_tvalid, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout cycles=%0d", cyc);
    $fatal(1, "bench timeout");
  end
  initial begin
    ctrl_start = 0;
    s_axis_tdata = 0;
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    m_axis_tready = 0;
    sa_start_rd_wr = RD_WR_IDLE;
    sa_data_out = 0;
    sa_done = 0;
    #2 rstn = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1;
    run_job(100, 1, -1, IW - 1, 1, 0, 0);
    run_job(30, 0, -1, IW - 1, 2, 0, 1);
    run_job(70, 0, -1, IW - 1, 0, 1, 0);
    run_job(100, 0, 5, IW - 1, 2, 0, 0);
    run_job(60, 0, -1, 10, 1, 0, 0);
    do_abort();
    run_job(100, 1, -1, IW - 1, 0, 0, 0);
    for (int j = 0; j < 4; j++)
      run_job(int'($urandom_range(100, 20)), 0, -1, IW - 1, 2, 1'($urandom_range(1)), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sa_stream_bridge.md
Name: sa_stream_bridge

Overview:
- AXI-Stream adapter between the AXI DMA and the systolic-array core.
- Ingress: forwards exactly IN_WORDS 32-bit beats from the slave stream into the core's load port (sa_read_data_vld / sa_data_in) when the core requests data.
- Egress: captures OUT_WORDS results that the core emits at one word per clock with no backpressure, buffers them, and drains them to the master stream with TLAST on the final beat.
- Also sequences the start pulse and reports done/error to the PS control registers.

Parameters:
- IN_WORDS, 32, beats forwarded per job (16 A words + 16 B words).
- OUT_WORDS, 16, result words captured and streamed per job.
- CAPTURE_DELAY, 2, cycles from sampling sa_start_rd_wr==2'b11 to the first valid sa_data_out word. Covers the core's address cycle plus 1-cycle DPRAM read latency.

Ports:
- Clock and reset (already decided): clk, clock; rstn, reset, asynchronous, active-low.
- ctrl_start  in  1  PS job request; level or pulse, rising edge used.
- ctrl_busy  out  1  job in progress.
- ctrl_done  out  1  one-cycle pulse at job completion.
- ctrl_err  out  1  sticky protocol error; cleared by next accepted ctrl_start.
- s_axis_tdata  in  32  DMA input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input last.
- m_axis_tdata  out  32  result data.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  result ready.
- m_axis_tlast  out  1  high on beat OUT_WORDS-1.
- sa_start  out  1  one-cycle start to core.
- sa_start_rd_wr  in  2  core request: 2'b10 = wants input, 2'b11 = output ready.
- sa_read_data_vld  out  1  registered input strobe to core.
- sa_data_in  out  32  registered input data to core.
- sa_data_out  in  32  core result word.
- sa_done  in  1  core completion.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0; FIFO empty; sticky flags 0.
- Reset mid-operation: abort immediately; FIFO flushed; no ctrl_done pulse.

FSM states:
- IDLE: on rising edge of ctrl_start, pulse sa_start for exactly 1 cycle, clear ctrl_err, set busy, go to WAIT_RD. ctrl_start edges while busy are ignored.
- WAIT_RD: on sampling sa_start_rd_wr==2'b10, go to INGRESS with in_cnt=0.
- INGRESS:
  - s_axis_tready = 1 while in_cnt < IN_WORDS.
  - Each handshake: next cycle sa_read_data_vld=1 and sa_data_in=tdata; in_cnt++.
  - After handshake IN_WORDS-1: tready drops in the same cycle the count reaches IN_WORDS; go to WAIT_WR.
  - Gaps in tvalid are allowed; the core counts strobes only.
- WAIT_WR: on sampling sa_start_rd_wr==2'b11, load delay counter with CAPTURE_DELAY and go to CAPTURE.
- CAPTURE:
  - After the delay expires, write sa_data_out into the FIFO on each of OUT_WORDS consecutive cycles, unconditionally.
  - FIFO depth = OUT_WORDS, so overflow is impossible.
  - Drain runs concurrently. Go to DRAIN after the last write.
- DRAIN:
  - m_axis_tvalid = !fifo_empty; m_axis_tdata = FIFO head (first-word-fall-through).
  - tdata and tvalid are held stable while tvalid && !tready.
  - m_axis_tlast = (out_cnt == OUT_WORDS-1).
  - When the last beat is handshaken and the sa_done sticky flag is set: pulse ctrl_done, clear busy, go to IDLE. If sa_done has not yet arrived, wait for it.
- sa_done is captured into a sticky flag from sa_start onward.

Error conditions (set ctrl_err):
- sa_done seen before CAPTURE completes.
- sa_start_rd_wr==2'b11 seen during INGRESS.
- ctrl_err never blocks completion.

Timing and boundaries:
- Latency: input beat to core strobe = 1 cycle.
- Simultaneous FIFO write and read in the same cycle: count unchanged.
- Empty FIFO with tready high: no beat.
- Counters wrap only via explicit reset to 0 on state exit.

Optional Feature:
SA_STREAM_BRIDGE_TLAST_CHECK_EN
- Defined: during INGRESS, s_axis_tlast must equal (in_cnt==IN_WORDS-1) on every handshake; a mismatch sets ctrl_err. Beats are still forwarded.
- Undefined: s_axis_tlast is ignored and the check logic is absent.

Decomposition:
- Shared package sa_pkg:
  - state enum/localparams for this bridge;
  - RD_WR_IDLE=2'b00, RD_WR_LOAD=2'b10, RD_WR_OUT=2'b11;
  - default IN_WORDS/OUT_WORDS, shared with the core.
- One sub-module: sa_sync_fifo (parameterised DW/DEPTH, FWFT, count/empty/full), used for the egress buffer.

Test Plan:
- Nominal job:
  - ctrl_start pulse, then core model raises 2'b10.
  - Stream 32 beats 0x00000000..0x0000001F with tvalid always high.
  - Expect 32 sa_read_data_vld strobes with matching data, each 1 cycle after its handshake; tready low after beat 31.
- Egress with backpressure:
  - Core raises 2'b11 and emits 0xA0..0xAF from cycle +2.
  - m_axis_tready toggles 1/0.
  - Expect 16 beats 0xA0..0xAF in order, tlast only on 0xAF, then one ctrl_done pulse with sa_done already high.
- Ingress stalls: tvalid random 30% duty -> exactly 32 strobes, data order preserved, no extra strobe.
- Late done: last m_axis beat accepted, sa_done raised 5 cycles later -> ctrl_done exactly on the cycle after sa_done is sampled; busy high until then.
- Reset mid-CAPTURE: rstn low after 7 words captured -> all outputs 0, m_axis_tvalid 0; a fresh job afterwards completes normally with 16 beats.
- Protocol error:
  - sa_done pulsed during INGRESS -> ctrl_err=1, held until next ctrl_start.
  - With SA_STREAM_BRIDGE_TLAST_CHECK_EN defined, tlast on beat 10 -> ctrl_err=1.
